// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side FIFO drain with a 2-entry skid buffer; define FIFO_RD_WORDCNT_EN to add the wordCount port.
`ifndef WIDTH
`define WIDTH 8
`endif
module fifo_rd_drain #(
  parameter int DATA_W = `WIDTH
) (
  input  logic              rdClk,
  input  logic              reset,
  input  logic              empty,
  input  logic              underflow,
  input  logic [DATA_W-1:0] rdata,
  output logic              rdEn,
  output logic              outValid,
  output logic [DATA_W-1:0] outData,
  input  logic              outReady,
  input  logic              clrErr,
  output logic              errUnderflow
`ifdef FIFO_RD_WORDCNT_EN
  ,
  output logic [15:0]       wordCount
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;
  logic pending_q, pending_d, err_q, err_d, pop, cap;
  logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [2:0] occ;
  assign outValid     = state_q != EMPTY;
  assign outData      = buf0_q;
  assign errUnderflow = err_q;
  assign pop          = outValid && outReady;
  assign cap          = pending_q && !underflow;
  assign occ          = {1'b0, state_q} + {2'b0, pending_q} - {2'b0, pop};
  assign rdEn         = reset && !empty && occ <= 3'd1;
  // skid occupancy FSM, entry writes, in-flight tracking and sticky fault flag
  always_comb begin
    state_d   = state_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    pending_d = rdEn;
    err_d     = underflow || (err_q && !clrErr);
    case (state_q)
      EMPTY: if (cap) begin
        state_d = ONE;
        buf0_d  = rdata;
      end
      ONE: if (cap && pop) buf0_d = rdata;
      else if (cap) begin
        state_d = FULL;
        buf1_d  = rdata;
      end else if (pop) state_d = EMPTY;
      FULL: if (pop) begin
        state_d = ONE;
        buf0_d  = buf1_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  // state registers; reset drops any in-flight read
  always_ff @(posedge rdClk or negedge reset) begin
    if (!reset) begin
      state_q   <= EMPTY;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
    end
  end
`ifdef FIFO_RD_WORDCNT_EN
  logic [15:0] wc_q, wc_d;
  assign wordCount = wc_q;
  // wrapping count of output handshakes
  always_comb wc_d = wc_q + {15'd0, pop};
  // handshake counter register
  always_ff @(posedge rdClk or negedge reset) begin
    if (!reset) wc_q <= '0;
    else wc_q <= wc_d;
  end
`endif
endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain engine for the dual-clock FIFO. It sits entirely in the `rdClk` domain and is the reader that empties the FIFO read port (`rdEn`, `rdata`, `empty`, `underflow`). It converts the FIFO's fixed one-cycle read latency into a valid/ready output stream through a 2-entry skid buffer, sustaining one word per cycle. It also flags protocol faults reported by the FIFO.

## Interface
- `DATA_W`, default `` `WIDTH ``, FIFO word width; must match the FIFO `rdata` width.
- `rdClk` in 1, read-domain clock; all logic on its rising edge.
- `reset` in 1, asynchronous, active-low reset.
- `empty` in 1, FIFO empty flag, synchronous to `rdClk`.
- `underflow` in 1, FIFO underflow pulse, valid in the cycle after an illegal read.
- `rdata` in DATA_W, FIFO read data, valid one cycle after an accepted `rdEn`.
- `rdEn` out 1, FIFO read request; combinational from registered state, `empty` and `outReady`.
- `outValid` out 1, output word available.
- `outData` out DATA_W, output word, the head of the skid buffer.
- `outReady` in 1, downstream accepts `outData` when it is high together with `outValid`.
- `clrErr` in 1, single-cycle clear of `errUnderflow`.
- `errUnderflow` out 1, sticky fault flag.
- `wordCount` out 16, output handshake count; present only with `FIFO_RD_WORDCNT_EN`.

## Operation
- State:
  - `pending`: 1 bit; a read was issued last cycle and its data arrives this cycle.
  - `count`: 0..2; occupied skid entries, FSM states EMPTY, ONE, FULL.
  - `buf0`, `buf1`: skid entries; `buf0` is the head.
- Pop: `pop = outValid && outReady`.
- Issue rule: `rdEn = reset && !empty && (count + pending - pop) <= 1`. This never overfills the buffer.
- Capture: when `pending` is high and `underflow` is low, `rdata` is written into the next free entry after any pop.
- Dropped read: when `pending` and `underflow` are both high, the word is dropped and `errUnderflow` is set.
- Transitions, with `cap` = capture this cycle:
  - EMPTY → ONE on `cap`.
  - ONE → FULL on `cap && !pop`.
  - ONE → EMPTY on `pop && !cap`.
  - ONE stays ONE on `pop && cap`: `buf0` takes `rdata`.
  - FULL → ONE on `pop`: `buf0` takes `buf1`. In FULL, `cap && pop` is unreachable under the issue rule.
- Outputs: `outValid = (count != 0)`; `outData = buf0`.
- Output protocol: `outData` holds stable while `outValid && !outReady`.
- `errUnderflow` set/clear: set on `underflow` sampled high in any cycle, whether or not `pending`. Cleared by `clrErr`; set wins when both occur in the same cycle.
- Word order: output order equals FIFO read order; no word is duplicated.

## Timing
- Reset values while `reset` is low: `rdEn` 0, `outValid` 0, `outData` 0, `errUnderflow` 0, `pending` 0, `count` 0, `wordCount` 0.
- Reset mid-operation: an in-flight read is discarded; its FIFO word is lost by design. The first `rdEn` is possible in the first cycle after `reset` deasserts.
- Latency: `rdEn` high at edge N → word captured at edge N+1 → `outValid` high after edge N+1.
- Empty-to-output latency is therefore 1 cycle after the read is accepted.
- Throughput: with `outReady` tied high and FIFO non-empty, `rdEn` stays high every cycle and one word leaves per cycle after a 1-cycle fill.
- Backpressure: with `outReady` low, at most 2 further words are read (one buffered, one in flight), then `rdEn` drops. `rdEn` reasserts in the same cycle `outReady` returns high.
- `empty` asserting: `rdEn` goes low combinationally; an in-flight read still completes.
- Simultaneous events: capture and pop in one cycle keep `count` unchanged.

## Configuration
- `FIFO_RD_WORDCNT_EN` defined:
  - `wordCount` port exists.
  - 16-bit counter increments on each `pop`; wraps 16'hFFFF → 16'h0000.
  - Cleared only by `reset`.
- Undefined: the `wordCount` port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, FIFO preloaded with 0x11, 0x22, 0x33, `outReady`=1 → `rdEn` high 3 cycles; `outData` 0x11, 0x22, 0x33 on consecutive cycles starting 1 cycle after the first `rdEn`; `wordCount`=3.
- `outReady`=0, FIFO holds 5 words → exactly 2 `rdEn` pulses, `outValid`=1, `outData`=first word held stable. Raise `outReady` → remaining 5 words delivered in order, no gaps once streaming.
- Inject `underflow`=1 in the capture cycle of word 0xAA → 0xAA not delivered, `errUnderflow`=1. Pulse `clrErr` → 0. Pulse `clrErr` and `underflow` together → stays 1.
- Assert `reset` low with `pending`=1 and `count`=2 → all outputs 0 immediately (asynchronous). After release, the next FIFO word is delivered first.
- Alternate `outReady` 1/0 every cycle over 100 random words → output sequence equals FIFO input sequence; `count` never exceeds 2.
- With `FIFO_RD_WORDCNT_EN`: 65537 words → `wordCount`=1 (wrap).
